// File: rtl/chunked_wide_adder_if.sv
// Request/response bundle for chunked_wide_adder: operands and opcode in,
// handshake, result and flags out.
interface chunked_wide_adder_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] operand_A_i;
  logic [DATA_WIDTH-1:0] operand_B_i;
  logic                  carry_i;
  logic                  subtract_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  carry_o;
  logic                  overflow_o;

  modport master (
    output valid_i, operand_A_i, operand_B_i, carry_i, subtract_i,
    input  ready_o, valid_o, result_o, carry_o, overflow_o
  );

  modport slave (
    input  valid_i, operand_A_i, operand_B_i, carry_i, subtract_i,
    output ready_o, valid_o, result_o, carry_o, overflow_o
  );
endinterface

// File: rtl/chunked_wide_adder.sv
// Multi-cycle wide add/sub: one CHUNK_WIDTH slice per cycle through a single
// ripple-carry adder, carry registered between slices.
module ripple_carry_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

module chunked_wide_adder #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  chunked_wide_adder_if.slave  bus
);
  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 2) ? $clog2(NUM_CHUNKS) : 1;

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || NUM_CHUNKS < 2) begin : g_bad_cfg
    $error("chunked_wide_adder: DATA_WIDTH must be a multiple of CHUNK_WIDTH with >= 2 chunks");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q, acc_q;
  logic                   carry_q, a_msb_q, b_msb_q;
  logic [CHUNK_WIDTH-1:0] slice_sum;
  logic                   slice_cout;
  logic                   accept, last_slice;

  // Operands shift down one slice per cycle, so the adder always sees the low slice.
  ripple_carry_adder #(.WIDTH(CHUNK_WIDTH)) u_rca (
    .a    (a_q[CHUNK_WIDTH-1:0]),
    .b    (b_q[CHUNK_WIDTH-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    accept      = 1'b0;
    last_slice  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        last_slice = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        bus.valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      carry_q        <= 1'b0;
      a_msb_q        <= 1'b0;
      b_msb_q        <= 1'b0;
      cnt_q          <= '0;
      bus.result_o   <= '0;
      bus.carry_o    <= 1'b0;
      bus.overflow_o <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.operand_A_i;
      b_q     <= bus.subtract_i ? ~bus.operand_B_i : bus.operand_B_i;
      carry_q <= bus.subtract_i | bus.carry_i;
      a_msb_q <= bus.operand_A_i[DATA_WIDTH-1];
      b_msb_q <= bus.subtract_i ? ~bus.operand_B_i[DATA_WIDTH-1] : bus.operand_B_i[DATA_WIDTH-1];
      cnt_q   <= '0;
    end else if (state_q == ADD) begin
      a_q     <= a_q >> CHUNK_WIDTH;
      b_q     <= b_q >> CHUNK_WIDTH;
      carry_q <= slice_cout;
      // Slices enter at the top; after NUM_CHUNKS shifts slice 0 sits at the bottom.
      acc_q   <= {slice_sum, acc_q[DATA_WIDTH-1:CHUNK_WIDTH]};
      cnt_q   <= last_slice ? '0 : cnt_q + CNT_W'(1);
      if (last_slice) begin
        bus.result_o   <= {slice_sum, acc_q[DATA_WIDTH-1:CHUNK_WIDTH]};
        bus.carry_o    <= slice_cout;
        bus.overflow_o <= (a_msb_q == b_msb_q) && (slice_sum[CHUNK_WIDTH-1] != a_msb_q);
      end
    end
  end
endmodule
